// File: rtl/hwt_response_monitor.sv
// Response monitor for a hardware-trojan test harness: compares the device response
// against a golden response, compacts accepted vectors into a MISR and watches for a trigger.
module hwt_response_monitor #(
    parameter int          CNT_W = 8,
    parameter logic [15:0] SEED  = 16'hFFFF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             sample_valid,
    input  logic             A,
    input  logic             B,
    input  logic             C,
    input  logic             D,
    input  logic             Y,
    input  logic             exp_y,
    output logic             busy,
    output logic             done,
    output logic [15:0]      signature,
    output logic [CNT_W-1:0] vec_count,
    output logic [CNT_W-1:0] mism_count,
    output logic [4:0]       first_vec,
    output logic [CNT_W-1:0] first_idx,
    output logic             trigger_seen,
    output logic             alarm
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
    typedef enum logic [1:0] {S0, S1, S2} det_e;

    state_e           state_q, state_d;
    det_e             det_q, det_d;
    logic [15:0]      sig_q, sig_d;
    logic [CNT_W-1:0] vc_q, vc_d;
    logic [CNT_W-1:0] mc_q, mc_d;
    logic [4:0]       fv_q, fv_d;
    logic [CNT_W-1:0] fi_q, fi_d;
    logic             trig_q, trig_d;
    logic             alarm_q, alarm_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic       accept;
    logic [3:0] abcd;
    logic [4:0] vec;
    logic       fb;

    assign abcd   = {A, B, C, D};
    assign vec    = {A, B, C, D, Y};
    assign fb     = sig_q[15] ^ sig_q[13] ^ sig_q[12] ^ sig_q[10];
    // A start in the same cycle wins over any sample presented alongside it.
    assign accept = sample_valid && (state_q == RUN) && !start;

    always_comb begin
        state_d = state_q;
        det_d   = det_q;
        sig_d   = sig_q;
        vc_d    = vc_q;
        mc_d    = mc_q;
        fv_d    = fv_q;
        fi_d    = fi_q;
        trig_d  = trig_q;
        if (start) begin
            state_d = RUN;
            det_d   = S0;
            sig_d   = SEED;
            vc_d    = '0;
            mc_d    = '0;
            fv_d    = '0;
            fi_d    = '0;
            trig_d  = 1'b0;
        end else begin
            if (accept) begin
                sig_d = {sig_q[14:0], fb} ^ {11'b0, vec};
                if (vc_q != '1)
                    vc_d = vc_q + CNT_W'(1);
                if (Y != exp_y) begin
                    // mism_count only clears on start, so zero marks the run's first mismatch.
                    if (mc_q == '0) begin
                        fv_d = vec;
                        fi_d = vc_q;
                    end
                    if (mc_q != '1)
                        mc_d = mc_q + CNT_W'(1);
                end
                if (abcd == 4'b1111)
                    det_d = S1;
                else if (det_q == S1 && abcd == 4'b0111)
                    det_d = S2;
                else if (det_q == S2 && abcd == 4'b0011) begin
                    det_d  = S0;
                    trig_d = 1'b1;
                end else
                    det_d = S0;
            end
            if (state_q == RUN && stop)
                state_d = DONE;
        end
        alarm_d = trig_d | (mc_d != '0);
        busy_d  = (state_d == RUN);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            det_q   <= S0;
            sig_q   <= SEED;
            vc_q    <= '0;
            mc_q    <= '0;
            fv_q    <= '0;
            fi_q    <= '0;
            trig_q  <= 1'b0;
            alarm_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            det_q   <= det_d;
            sig_q   <= sig_d;
            vc_q    <= vc_d;
            mc_q    <= mc_d;
            fv_q    <= fv_d;
            fi_q    <= fi_d;
            trig_q  <= trig_d;
            alarm_q <= alarm_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign signature    = sig_q;
    assign vec_count    = vc_q;
    assign mism_count   = mc_q;
    assign first_vec    = fv_q;
    assign first_idx    = fi_q;
    assign trigger_seen = trig_q;
    assign alarm        = alarm_q;

endmodule

// File: tb/tb_hwt_response_monitor.sv
// Scoreboard bench for hwt_response_monitor: a behavioural model pushes expected outputs
// per driven cycle; they are popped and compared after the following clock edge.
module tb_hwt_response_monitor;

    localparam int CW   = 4;
    localparam int MAXC = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0, stop = 1'b0, sample_valid = 1'b0;
    logic A = 1'b0, B = 1'b0, C = 1'b0, D = 1'b0, Y = 1'b0, exp_y = 1'b0;
    logic          busy, done, trigger_seen, alarm;
    logic [15:0]   signature;
    logic [CW-1:0] vec_count, mism_count, first_idx;
    logic [4:0]    first_vec;

    hwt_response_monitor #(.CNT_W(CW), .SEED(16'hFFFF)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .sample_valid(sample_valid), .A(A), .B(B), .C(C), .D(D), .Y(Y), .exp_y(exp_y),
        .busy(busy), .done(done), .signature(signature), .vec_count(vec_count),
        .mism_count(mism_count), .first_vec(first_vec), .first_idx(first_idx),
        .trigger_seen(trigger_seen), .alarm(alarm)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        busy, done, trig, alarm;
        logic [15:0] sig;
        int          vc, mc, fi;
        logic [4:0]  fv;
    } exp_t;

    exp_t exp_q[$];
    int total = 0;
    int bad   = 0;

    // model state: 0 idle, 1 run, 2 done; detector 0/1/2
    int          m_st, m_det, m_vc, m_mc, m_fi;
    logic [15:0] m_sig;
    logic [4:0]  m_fv;
    logic        m_trig;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, expv);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_det = 0; m_vc = 0; m_mc = 0; m_fi = 0;
        m_sig = 16'hFFFF; m_fv = '0; m_trig = 1'b0;
    endtask

    task automatic model_step(input logic st, input logic sp, input logic sv,
                              input logic [3:0] abcd, input logic y, input logic ey);
        logic [4:0] v;
        logic       f;
        v = {abcd, y};
        if (st) begin
            model_reset();
            m_st = 1;
        end else begin
            if (m_st == 1 && sv) begin
                f = m_sig[15] ^ m_sig[13] ^ m_sig[12] ^ m_sig[10];
                m_sig = {m_sig[14:0], f} ^ {11'b0, v};
                if (y != ey) begin
                    if (m_mc == 0) begin
                        m_fv = v;
                        m_fi = m_vc;
                    end
                    m_mc = (m_mc + 1 > MAXC) ? MAXC : m_mc + 1;
                end
                m_vc = (m_vc + 1 > MAXC) ? MAXC : m_vc + 1;
                case (abcd)
                    4'b1111: m_det = 1;
                    4'b0111: m_det = (m_det == 1) ? 2 : 0;
                    4'b0011: begin
                        if (m_det == 2) m_trig = 1'b1;
                        m_det = 0;
                    end
                    default: m_det = 0;
                endcase
            end
            if (m_st == 1 && sp) m_st = 2;
        end
    endtask

    function automatic exp_t model_snapshot();
        exp_t e;
        e.busy  = (m_st == 1);
        e.done  = (m_st == 2);
        e.trig  = m_trig;
        e.alarm = m_trig || (m_mc != 0);
        e.sig   = m_sig;
        e.vc    = m_vc;
        e.mc    = m_mc;
        e.fi    = m_fi;
        e.fv    = m_fv;
        return e;
    endfunction

    task automatic compare_outputs();
        exp_t e;
        check("sb_depth", exp_q.size(), 1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("busy", busy, e.busy);
            check("done", done, e.done);
            check("signature", signature, e.sig);
            check("vec_count", vec_count, e.vc);
            check("mism_count", mism_count, e.mc);
            check("first_vec", first_vec, e.fv);
            check("first_idx", first_idx, e.fi);
            check("trigger_seen", trigger_seen, e.trig);
            check("alarm", alarm, e.alarm);
        end
    endtask

    task automatic step(input logic st, input logic sp, input logic sv,
                        input logic [3:0] abcd, input logic y, input logic ey);
        @(negedge clk);
        start = st; stop = sp; sample_valid = sv;
        {A, B, C, D} = abcd; Y = y; exp_y = ey;
        model_step(st, sp, sv, abcd, y, ey);
        exp_q.push_back(model_snapshot());
        @(posedge clk);
        #1;
        compare_outputs();
        $display("step st=%0b sp=%0b sv=%0b abcdy=%b ey=%0b -> sig=%h vc=%0d mc=%0d trig=%0b alarm=%0b",
                 st, sp, sv, {abcd, y}, ey, signature, vec_count, mism_count, trigger_seen, alarm);
    endtask

    task automatic vec(input logic [3:0] abcd, input logic y, input logic ey);
        step(1'b0, 1'b0, 1'b1, abcd, y, ey);
    endtask

    // Asserts reset between edges so the asynchronous clear is observed before any clock.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sig", signature, 16'hFFFF);
        check("rst_vc", vec_count, 0);
        check("rst_mc", mism_count, 0);
        check("rst_fv", first_vec, 0);
        check("rst_fi", first_idx, 0);
        check("rst_trig", trigger_seen, 0);
        check("rst_alarm", alarm, 0);
        model_reset();
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] pick;
        model_reset();
        do_reset();
        step(1'b0, 1'b0, 1'b1, 4'b1111, 1'b1, 1'b0); // IDLE ignores samples

        // single vector signature
        step(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
        vec(4'b1000, 1'b0, 1'b0);
        check("one_vec_sig", signature, 16'hFFEE);
        check("one_vec_vc", vec_count, 1);
        check("one_vec_mc", mism_count, 0);
        check("one_vec_alarm", alarm, 0);

        // trigger sequence
        step(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
        vec(4'b1111, 1'b0, 1'b0);
        vec(4'b0111, 1'b0, 1'b0);
        check("trig_early", trigger_seen, 0);
        vec(4'b0011, 1'b0, 1'b0);
        check("trig_set", trigger_seen, 1);
        check("trig_alarm", alarm, 1);
        vec(4'b0101, 1'b1, 1'b1);
        check("trig_sticky", trigger_seen, 1);

        // broken trigger sequence
        step(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
        vec(4'b1111, 1'b0, 1'b0);
        vec(4'b0000, 1'b0, 1'b0);
        vec(4'b0111, 1'b0, 1'b0);
        vec(4'b0011, 1'b0, 1'b0);
        check("notrig", trigger_seen, 0);

        // mismatches at vectors 3 and 5
        step(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
        vec(4'b0000, 1'b0, 1'b0);
        vec(4'b0001, 1'b1, 1'b1);
        vec(4'b0110, 1'b1, 1'b0);
        vec(4'b1000, 1'b0, 1'b0);
        vec(4'b1010, 1'b0, 1'b1);
        check("mism_count2", mism_count, 2);
        check("first_idx2", first_idx, 2);
        check("first_vec", first_vec, 5'b01101);
        check("mism_alarm", alarm, 1);

        // saturation, stop, frozen results
        step(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            pick = 4'($urandom_range(0, 15));
            vec(pick, i[0], i[0]);
        end
        check("vc_sat", vec_count, 15);
        step(1'b0, 1'b1, 1'b1, 4'b0110, 1'b1, 1'b0); // sample with stop is still processed
        check("stop_done", done, 1);
        check("stop_mc", mism_count, 1);
        for (int i = 0; i < 4; i++)
            vec(4'b1111, 1'b1, 1'b0);
        check("frozen_mc", mism_count, 1);

        // start+stop together in RUN, sample ignored
        step(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
        vec(4'b0100, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 4'b1111, 1'b1, 1'b0);
        check("ss_busy", busy, 1);
        check("ss_vc", vec_count, 0);
        check("ss_sig", signature, 16'hFFFF);

        // reset mid-run
        vec(4'b1111, 1'b1, 1'b0);
        vec(4'b0111, 1'b0, 1'b0);
        do_reset();
        step(1'b0, 1'b0, 1'b1, 4'b0011, 1'b0, 1'b0);
        check("post_rst_busy", busy, 0);
        check("post_rst_trig", trigger_seen, 0);

        // random traffic with trigger-biased stimulus
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 3))
                0: pick = 4'b1111;
                1: pick = 4'b0111;
                2: pick = 4'b0011;
                default: pick = 4'($urandom_range(0, 15));
            endcase
            step(($urandom_range(0, 19) == 0), ($urandom_range(0, 14) == 0),
                 ($urandom_range(0, 3) != 0), pick,
                 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
